// File: rtl/demux12_stream_pkg.sv
// Shared definitions for the 1:2 stream steering block.
// Route select sense matches the 2:1 select mux (0 = A, 1 = B).
// Stage state encoding is shared by both output register slices.
package demux12_stream_pkg;

  // Route select values carried on in_sel.
  localparam logic STREAM_SEL_A = 1'b0;
  localparam logic STREAM_SEL_B = 1'b1;

  // One-entry stage occupancy; FULL is exactly "output valid".
  typedef enum logic {
    STAGE_EMPTY = 1'b0,
    STAGE_FULL  = 1'b1
  } stage_state_t;

  // A single-entry slice can take a new word when it is empty or when
  // its current word leaves in this same cycle.
  function automatic logic stage_can_take(input logic vld, input logic rdy);
    return (!vld) || rdy;
  endfunction

endpackage

// File: rtl/demux12_stream_stage.sv
// Single-entry valid/ready register slice with a wrapping delivery counter.
// Latency: one cycle from load to valid; data is registered, no comb data path.
// Backpressure: holds its word while valid & !ready; accepts a replacement word in the draining cycle.
module demux12_stream_stage
  import demux12_stream_pkg::*;
#(
  parameter int Data_Width = 32,
  parameter int Cnt_Width  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [Data_Width-1:0] load_data,
  output logic                  take_ok,
  output logic [Data_Width-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic [Cnt_Width-1:0]  count
);

  stage_state_t          state_q;
  stage_state_t          state_d;
  logic                  drain;
  logic [Data_Width-1:0] data_q;
  logic [Cnt_Width-1:0]  count_q;

  assign valid   = (state_q == STAGE_FULL);
  assign drain   = valid & ready;
  assign take_ok = stage_can_take(valid, ready);
  assign data    = data_q;
  assign count   = count_q;

  // Occupancy register; a buffered word is dropped on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STAGE_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy: fill on load, empty on drain without a refill, else hold.
  always_comb begin
    state_d = state_q;
    case (state_q)
      STAGE_EMPTY: begin
        if (load) begin
          state_d = STAGE_FULL;
        end
      end
      STAGE_FULL: begin
        if (drain && !load) begin
          state_d = STAGE_EMPTY;
        end
      end
      default: begin
        state_d = STAGE_EMPTY;
      end
    endcase
  end

  // Word register loads only on accept, so it stays put while stalled or empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= load_data;
    end
  end

  // Delivery counter for debug; wraps naturally at 2^Cnt_Width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (drain) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/demux12_stream.sv
// Steers one valid/ready stream to sink A or sink B by a per-word select bit.
// Latency: one cycle (registered stage per output), no comb in->out data path.
// Backpressure: in_ready follows only the selected output; a stalled sink never blocks words for the other.
module demux12_stream
  import demux12_stream_pkg::*;
#(
  parameter int Data_Width = 32,
  parameter int Cnt_Width  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [Data_Width-1:0] in_data,
  input  logic                  in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [Data_Width-1:0] a_data,
  output logic                  a_valid,
  input  logic                  a_ready,
  output logic [Data_Width-1:0] b_data,
  output logic                  b_valid,
  input  logic                  b_ready,
  output logic [Cnt_Width-1:0]  a_count,
  output logic [Cnt_Width-1:0]  b_count
);

  logic a_take_ok;
  logic b_take_ok;
  logic acc_a;
  logic acc_b;

  // Input handshake depends only on the selected slice, never on the other one.
  always_comb begin
    in_ready = a_take_ok;
    acc_a    = 1'b0;
    acc_b    = 1'b0;
    if (in_sel == STREAM_SEL_B) begin
      in_ready = b_take_ok;
      acc_b    = in_valid & b_take_ok;
    end else begin
      acc_a    = in_valid & a_take_ok;
    end
  end

  demux12_stream_stage #(
    .Data_Width (Data_Width),
    .Cnt_Width  (Cnt_Width)
  ) u_stage_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (acc_a),
    .load_data (in_data),
    .take_ok   (a_take_ok),
    .data      (a_data),
    .valid     (a_valid),
    .ready     (a_ready),
    .count     (a_count)
  );

  demux12_stream_stage #(
    .Data_Width (Data_Width),
    .Cnt_Width  (Cnt_Width)
  ) u_stage_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (acc_b),
    .load_data (in_data),
    .take_ok   (b_take_ok),
    .data      (b_data),
    .valid     (b_valid),
    .ready     (b_ready),
    .count     (b_count)
  );

endmodule

// File: tb/tb_demux12_stream.sv
// Scoreboard bench for demux12_stream (4-bit counters to exercise wrap).
// Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.
// Expected words are queued per output at accept and compared at delivery.
module tb_demux12_stream;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a_data;
  logic          a_valid;
  logic          a_ready;
  logic [DW-1:0] b_data;
  logic          b_valid;
  logic          b_ready;
  logic [CW-1:0] a_count;
  logic [CW-1:0] b_count;

  demux12_stream #(
    .Data_Width (DW),
    .Cnt_Width  (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  logic [CW-1:0] exp_a_cnt = '0;
  logic [CW-1:0] exp_b_cnt = '0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard monitor: occupancy, ready, counters and delivered data against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("a_valid", {31'b0, a_valid}, {31'b0, qa.size() != 0});
      check("b_valid", {31'b0, b_valid}, {31'b0, qb.size() != 0});
      check("a_count", {28'b0, a_count}, {28'b0, exp_a_cnt});
      check("b_count", {28'b0, b_count}, {28'b0, exp_b_cnt});
      check("in_ready", {31'b0, in_ready},
            {31'b0, in_sel ? (qb.size() == 0 || b_ready) : (qa.size() == 0 || a_ready)});
      if (a_valid && qa.size() != 0) begin
        check("a_data", a_data, qa[0]);
        if (a_ready) begin
          void'(qa.pop_front());
          exp_a_cnt = exp_a_cnt + 1'b1;
        end
      end
      if (b_valid && qb.size() != 0) begin
        check("b_data", b_data, qb[0]);
        if (b_ready) begin
          void'(qb.pop_front());
          exp_b_cnt = exp_b_cnt + 1'b1;
        end
      end
      if (in_valid && in_ready) begin
        if (in_sel) qb.push_back(in_data);
        else        qa.push_back(in_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic s);
    in_valid = v;
    in_data  = d;
    in_sel   = s;
  endtask

  // Asynchronous reset asserted mid-cycle; the model is cleared with it.
  task automatic reset_dut();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    qa.delete();
    qb.delete();
    exp_a_cnt = '0;
    exp_b_cnt = '0;
    #1;
    check("rst a_valid", {31'b0, a_valid}, 32'd0);
    check("rst b_valid", {31'b0, b_valid}, 32'd0);
    check("rst a_count", {28'b0, a_count}, 32'd0);
    check("rst b_count", {28'b0, b_count}, 32'd0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    a_ready = 1'b0;
    b_ready = 1'b0;
    drive(1'b0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #6;
    check("por a_data", a_data, 32'd0);
    check("por b_data", b_data, 32'd0);
    check("por a_valid", {31'b0, a_valid}, 32'd0);
    check("por b_valid", {31'b0, b_valid}, 32'd0);
    check("por in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;

    // Single route to A.
    tick();
    a_ready = 1'b1;
    drive(1'b1, 32'hDEADBEEF, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0);
    #1;
    check("single a_valid", {31'b0, a_valid}, 32'd1);
    check("single a_data", a_data, 32'hDEADBEEF);
    check("single b_valid", {31'b0, b_valid}, 32'd0);
    tick();
    check("single a_count", {28'b0, a_count}, 32'd1);

    // Eight back-to-back words to B.
    b_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'hB000_0000 + i * 32'h11, 1'b1);
      #1;
      check("stream in_ready", {31'b0, in_ready}, 32'd1);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    tick();
    check("stream b_count", {28'b0, b_count}, 32'd8);

    // Isolation: A stalled with a word, B keeps flowing.
    a_ready = 1'b0;
    drive(1'b1, 32'h0000_00A1, 1'b0);
    tick();
    drive(1'b1, 32'h0000_00A2, 1'b0);
    #1;
    check("iso blocked", {31'b0, in_ready}, 32'd0);
    tick();
    tick();
    check("iso a_hold", a_data, 32'h0000_00A1);
    check("iso still blocked", {31'b0, in_ready}, 32'd0);
    drive(1'b1, 32'h0000_00B1, 1'b1);
    #1;
    check("iso b_open", {31'b0, in_ready}, 32'd1);
    tick();
    drive(1'b0, '0, 1'b0);
    #1;
    check("iso b_data", b_data, 32'h0000_00B1);
    check("iso b_valid", {31'b0, b_valid}, 32'd1);
    check("iso a_unchanged", a_data, 32'h0000_00A1);
    a_ready = 1'b1;
    tick();
    tick();

    // Both stages full, then reset mid-cycle.
    a_ready = 1'b0;
    b_ready = 1'b0;
    drive(1'b1, 32'h1111_1111, 1'b0);
    tick();
    drive(1'b1, 32'h2222_2222, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0);
    check("pre-rst a_valid", {31'b0, a_valid}, 32'd1);
    check("pre-rst b_valid", {31'b0, b_valid}, 32'd1);
    reset_dut();
    a_ready = 1'b1;
    b_ready = 1'b1;
    #1;
    check("post-rst in_ready", {31'b0, in_ready}, 32'd1);

    // Replace on drain: A holds 1, drains while 2 is accepted.
    a_ready = 1'b0;
    drive(1'b1, 32'h1, 1'b0);
    tick();
    check("rep a_data1", a_data, 32'h1);
    a_ready = 1'b1;
    drive(1'b1, 32'h2, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0);
    #1;
    check("rep a_valid", {31'b0, a_valid}, 32'd1);
    check("rep a_data2", a_data, 32'h2);
    check("rep a_count", {28'b0, a_count}, 32'd1);
    tick();
    tick();

    // Counter wrap: 17 deliveries on A with a 4-bit counter.
    reset_dut();
    a_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 32'hC000_0000 + i, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    tick();
    check("wrap a_count", {28'b0, a_count}, 32'd1);
    check("wrap a_valid", {31'b0, a_valid}, 32'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
